// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch/prefetch stage.
// NOP_INSTR is the bubble handed to decode whenever no instruction is presented.
// Optional feature macro used by the top: FETCH_PERF_CNT_EN.
package fetch_pkg;

    // Native width that the packed entry layout below is written for.
    localparam int FETCH_XLEN = 32;

    // Bubble instruction: bit pattern 01111 in the top bits, zeros below.
    localparam logic [31:0] NOP_INSTR = 32'h7800_0000;

    // Fetch sequencer states. At most one memory request is ever outstanding.
    //   IDLE : no request in flight, waiting for queue space
    //   REQ  : mem_req asserted, waiting for mem_gnt
    //   WAIT : granted, waiting for mem_rvalid; response is kept
    //   DROP : granted before a redirect, response will be discarded
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    // One prefetch queue entry. The queue stores {pc, instr} in this order,
    // so a packed entry of width 2*XLEN has pc in the upper half.
    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used as the prefetch queue.
// Clear has priority over push/pop. Push while full is accepted only when a
// pop happens in the same cycle; pop on empty is ignored.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so the
    // pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/fetch_prefetch.sv
// Fetch stage with a prefetch queue of (PC, instruction) pairs.
// Sequential word fetches run ahead of decode over a req/gnt/rvalid port;
// branch flush, interrupt restore and instruction injection are handled here.
// Optional feature: define FETCH_PERF_CNT_EN to add perf_fetched/perf_starve.
//
// Memory handshake: mem_req/mem_addr are held until a cycle with
// mem_req & mem_gnt, which is the only cycle the address is sampled. Exactly
// one mem_rvalid answers each grant, in a later cycle; mem_rvalid seen while
// no request is outstanding is ignored. Decode side: instr is taken whenever
// instr_valid & !stall, except injected instructions, which never pop the queue.
module fetch_prefetch
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] in_PC_next,
    input  logic            restore,
    input  logic [XLEN-1:0] PC_before_int,
    input  logic            use_cpu_injection,
    input  logic [XLEN-1:0] cpu_injection,
    input  logic            use_INT_INSTR,
    input  logic [XLEN-1:0] INT_INSTR,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] instr,
    output logic            instr_valid,
    output logic [XLEN-1:0] out_PC,
    output logic [XLEN-1:0] current_PC,
    output logic            Done,
    output logic [1:0]      dbg_state
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_starve
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [XLEN-1:0] NOP_X   = XLEN'(NOP_INSTR);
    localparam logic [XLEN-1:0] STEP_X  = XLEN'(PC_STEP);

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   target;
    logic              redirect;
    logic              inject;
    logic              push;
    logic              pop;
    logic [2*XLEN-1:0] q_wdata;
    logic [2*XLEN-1:0] q_rdata;
    logic [CW-1:0]     q_count;
    logic [CW-1:0]     count_push;
    logic              q_full;
    logic              q_empty;
    logic [XLEN-1:0]   head_pc;
    logic [XLEN-1:0]   head_instr;

    // Restore outranks flush; either one is a redirect.
    assign redirect = restore | flush;
    assign target   = restore ? PC_before_int : in_PC_next;
    assign inject   = use_cpu_injection | use_INT_INSTR;

    // Decode pops only real queue entries, never during a redirect or injection.
    assign pop = ~redirect & ~q_empty & ~stall & ~inject;

    // Occupancy after this cycle assuming a push lands (pop may free a slot).
    assign count_push = q_count + CW'(1) - CW'(pop);

    assign q_wdata    = {fetch_pc, mem_rdata};
    assign head_pc    = q_rdata[2*XLEN-1:XLEN];
    assign head_instr = q_rdata[XLEN-1:0];

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN)
    ) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (redirect),
        .push  (push),
        .pop   (pop),
        .wdata (q_wdata),
        .rdata (q_rdata),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    // Next-state logic of the fetch sequencer and the queue push decision.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        case (state)
            IDLE: begin
                // A redirect empties the queue, so space is guaranteed.
                if (redirect || !q_full) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_nxt = redirect ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    // A response arriving in the redirect cycle is already
                    // the stale one, so nothing is left to drop.
                    state_nxt = mem_rvalid ? REQ : DROP;
                end else if (mem_rvalid) begin
                    push      = 1'b1;
                    state_nxt = (count_push < DEPTH_C) ? REQ : IDLE;
                end
            end
            DROP: begin
                if (mem_rvalid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Fetch PC: jump on redirect, otherwise advance (mod 2^XLEN) per accepted word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
        end else if (redirect) begin
            fetch_pc <= target;
        end else if (push) begin
            fetch_pc <= fetch_pc + STEP_X;
        end
    end

    // Decode-facing instruction mux: redirect bubble, injections, queue head.
    always_comb begin
        instr       = NOP_X;
        instr_valid = 1'b0;
        if (!redirect) begin
            if (use_cpu_injection) begin
                instr       = cpu_injection;
                instr_valid = 1'b1;
            end else if (use_INT_INSTR) begin
                instr       = INT_INSTR;
                instr_valid = 1'b1;
            end else if (!q_empty) begin
                instr       = head_instr;
                instr_valid = 1'b1;
            end
        end
    end

    assign current_PC = q_empty ? fetch_pc : head_pc;
    assign out_PC     = current_PC;
    assign mem_req    = (state == REQ);
    assign mem_addr   = fetch_pc;
    assign Done       = push;
    assign dbg_state  = state;

`ifdef FETCH_PERF_CNT_EN
    // Saturating counters for fetched words and decode starvation cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_starve  <= '0;
        end else begin
            if (push && (perf_fetched != '1)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (q_empty && !redirect && !inject && (perf_starve != '1)) begin
                perf_starve <= perf_starve + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: memory responder returning addr ^ 32'hA5A5_0000,
// expected (pc, instr) pairs queued per scenario and checked when decode takes them.
module tb_fetch_prefetch;
  import fetch_pkg::*;

  localparam logic [31:0] XOR_KEY = 32'hA5A5_0000;
  localparam logic [31:0] NOP_EXP = 32'h7800_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        stall, flush, restore, use_cpu_injection, use_INT_INSTR;
  logic [31:0] in_PC_next, PC_before_int, cpu_injection, INT_INSTR;
  logic        mem_req, mem_gnt, mem_rvalid, instr_valid, Done;
  logic [31:0] mem_addr, mem_rdata, instr, out_PC, current_PC;
  logic [1:0]  dbg_state;

  // second instance: RESET_PC near the top of the address space, decode stalled
  logic        one_b, zero_b;
  logic [31:0] zero_w;
  logic        mem_req2, mem_gnt2, mem_rvalid2, instr_valid2, Done2;
  logic [31:0] mem_addr2, mem_rdata2, instr2, out_PC2, current_PC2;
  logic [1:0]  dbg_state2;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_starve, perf_fetched2, perf_starve2;
`endif

  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] exp_q[$];
  logic [31:0] addr2_q[$];
  bit          sb_on = 1'b0;
  int          rsp_delay = 1;
  int          gnt_pct = 100;

  fetch_prefetch dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_PC_next(in_PC_next),
    .restore(restore), .PC_before_int(PC_before_int),
    .use_cpu_injection(use_cpu_injection), .cpu_injection(cpu_injection),
    .use_INT_INSTR(use_INT_INSTR), .INT_INSTR(INT_INSTR),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .instr(instr), .instr_valid(instr_valid), .out_PC(out_PC),
    .current_PC(current_PC), .Done(Done), .dbg_state(dbg_state)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_starve(perf_starve)
`endif
  );

  fetch_prefetch #(.RESET_PC(WRAP_PC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .stall(one_b), .flush(zero_b), .in_PC_next(zero_w),
    .restore(zero_b), .PC_before_int(zero_w),
    .use_cpu_injection(zero_b), .cpu_injection(zero_w),
    .use_INT_INSTR(zero_b), .INT_INSTR(zero_w),
    .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_gnt(mem_gnt2),
    .mem_rvalid(mem_rvalid2), .mem_rdata(mem_rdata2),
    .instr(instr2), .instr_valid(instr_valid2), .out_PC(out_PC2),
    .current_PC(current_PC2), .Done(Done2), .dbg_state(dbg_state2)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched2), .perf_starve(perf_starve2)
`endif
  );

  // ---------------- memory responder for the main instance ----------------
  logic        acc;
  logic [31:0] acc_addr, pend_addr;
  bit          pend;
  int          pend_cnt;

  initial begin
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; pend = 1'b0; pend_cnt = 0;
    forever begin
      @(posedge clk);
      acc = mem_req && mem_gnt;
      acc_addr = mem_addr;
      #1;
      mem_rvalid = 1'b0;
      if (acc) begin
        pend = 1'b1; pend_cnt = rsp_delay; pend_addr = acc_addr;
      end
      if (pend) begin
        pend_cnt--;
        if (pend_cnt <= 0) begin
          mem_rvalid = 1'b1; mem_rdata = pend_addr ^ XOR_KEY; pend = 1'b0;
        end
      end
      mem_gnt = mem_req && !pend && ($urandom_range(0, 99) < gnt_pct);
    end
  end

  // ---------------- memory responder for the wrap instance ----------------
  logic        acc2;
  logic [31:0] acc2_addr;

  initial begin
    one_b = 1'b1; zero_b = 1'b0; zero_w = '0;
    mem_gnt2 = 1'b0; mem_rvalid2 = 1'b0; mem_rdata2 = '0;
    forever begin
      @(posedge clk);
      acc2 = mem_req2 && mem_gnt2;
      acc2_addr = mem_addr2;
      #1;
      mem_rvalid2 = 1'b0;
      if (acc2) begin
        addr2_q.push_back(acc2_addr);
        mem_rvalid2 = 1'b1; mem_rdata2 = acc2_addr ^ XOR_KEY;
      end
      mem_gnt2 = mem_req2;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; restore = 1'b0;
    use_cpu_injection = 1'b0; use_INT_INSTR = 1'b0;
    sb_on = 1'b0; exp_q.delete();
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One clock: scoreboard pops on an accepted queue instruction at the negedge.
  task automatic tick();
    fetch_entry_t e;
    @(negedge clk);
    if (sb_on && instr_valid && !stall && !use_cpu_injection && !use_INT_INSTR &&
        !flush && !restore && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (out_PC !== e.pc || instr !== e.instr) begin
        n_fail++;
        $display("FAIL sb_pop: got pc=%h instr=%h, expected pc=%h instr=%h",
                 out_PC, instr, e.pc, e.instr);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    logic [31:0] pc;
    for (int i = 0; i < n; i++) begin
      pc = start + 32'(4 * i);
      exp_q.push_back({pc, pc ^ XOR_KEY});
    end
  endtask

  task automatic drain(input int bound, input bit rand_stall, input string name);
    int n = 0;
    sb_on = 1'b1;
    while (exp_q.size() > 0 && n < bound) begin
      if (rand_stall) stall = ($urandom_range(0, 3) == 0);
      tick();
      n++;
    end
    stall = 1'b1;
    sb_on = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d entries left after %0d cycles, required 0", name, exp_q.size(), n);
    end
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    n_checks++;
    if (mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_wait_req: mem_req=%b, required 1", name, mem_req);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_checks += 3;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0 || Done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mem: req=%b addr=%h done=%b, required 0 00000000 0", mem_req, mem_addr, Done);
    end
    if (instr !== NOP_EXP || instr_valid !== 1'b0 || out_PC !== 32'h0 || current_PC !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_out: instr=%h valid=%b pc=%h cur=%h, required %h 0 0 0",
               instr, instr_valid, out_PC, current_PC, NOP_EXP);
    end
    if (dbg_state !== 2'd0 || dbg_state2 !== 2'd0 || Done2 !== 1'b0 || out_PC2 !== WRAP_PC || mem_addr2 !== WRAP_PC) begin
      n_fail++;
      $display("FAIL reset_state: st=%0d st2=%0d done2=%b pc2=%h addr2=%h, required 0 0 0 %h %h",
               dbg_state, dbg_state2, Done2, out_PC2, mem_addr2, WRAP_PC, WRAP_PC);
    end
  endtask

  task automatic test_stream();
    do_reset();
    rsp_delay = 1; gnt_pct = 100;
    push_seq(32'h0, 12);
    drain(200, 1'b0, "stream");
  endtask

  task automatic test_stall();
    do_reset();
    stall = 1'b1;
    repeat (14) tick();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (mem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_full_req: cycle %0d mem_req=%b, required 0", i, mem_req);
      end
      tick();
    end
    n_checks++;
    if (instr_valid !== 1'b1 || out_PC !== 32'h0 || instr !== XOR_KEY) begin
      n_fail++;
      $display("FAIL stall_head: valid=%b pc=%h instr=%h, required 1 00000000 %h", instr_valid, out_PC, instr, XOR_KEY);
    end
    stall = 1'b0;
    push_seq(32'h0, 4);
    drain(100, 1'b0, "stall");
  endtask

  task automatic test_flush();
    do_reset();
    rsp_delay = 1; gnt_pct = 100;
    wait_req("flush");
    tick();
    flush = 1'b1; in_PC_next = 32'h100;
    #1;
    n_checks++;
    if (Done !== 1'b0 || instr !== NOP_EXP || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_cycle: done=%b instr=%h valid=%b, required 0 %h 0", Done, instr, instr_valid, NOP_EXP);
    end
    push_seq(32'h100, 4);
    tick();
    flush = 1'b0;
    drain(100, 1'b0, "flush");
  endtask

  task automatic test_restore();
    do_reset();
    rsp_delay = 3; gnt_pct = 100;
    wait_req("restore");
    tick();
    stall = 1'b1; restore = 1'b1; flush = 1'b1; PC_before_int = 32'h40; in_PC_next = 32'h80;
    #1;
    n_checks++;
    if (instr_valid !== 1'b0 || instr !== NOP_EXP) begin
      n_fail++;
      $display("FAIL restore_cycle: valid=%b instr=%h, required 0 %h", instr_valid, instr, NOP_EXP);
    end
    tick();
    restore = 1'b0; flush = 1'b0; stall = 1'b0;
    #1;
    n_checks++;
    if (current_PC !== 32'h40 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL restore_target: cur=%h req=%b, required 00000040 0", current_PC, mem_req);
    end
    push_seq(32'h40, 4);
    drain(200, 1'b0, "restore");
    rsp_delay = 1;
  endtask

  task automatic test_redirect_req();
    do_reset();
    gnt_pct = 0;
    wait_req("redir_req");
    flush = 1'b1; in_PC_next = 32'h200;
    tick();
    flush = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin
      n_fail++;
      $display("FAIL redir_req_addr: req=%b addr=%h, required 1 00000200", mem_req, mem_addr);
    end
    gnt_pct = 100;
    push_seq(32'h200, 4);
    drain(100, 1'b0, "redir_req");
  endtask

  task automatic test_inject();
    do_reset();
    stall = 1'b1;
    repeat (14) tick();
    stall = 1'b0; use_cpu_injection = 1'b1; cpu_injection = 32'h1234_5678; INT_INSTR = 32'hCAFE_0001;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (instr !== 32'h1234_5678 || instr_valid !== 1'b1 || out_PC !== 32'h0) begin
        n_fail++;
        $display("FAIL inject_cpu: cycle %0d instr=%h valid=%b pc=%h, required 12345678 1 00000000", i, instr, instr_valid, out_PC);
      end
      tick();
    end
    use_INT_INSTR = 1'b1;
    #1;
    n_checks++;
    if (instr !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL inject_both: instr=%h, required 12345678", instr);
    end
    tick();
    use_cpu_injection = 1'b0;
    #1;
    n_checks++;
    if (instr !== 32'hCAFE_0001 || instr_valid !== 1'b1 || out_PC !== 32'h0) begin
      n_fail++;
      $display("FAIL inject_int: instr=%h valid=%b pc=%h, required cafe0001 1 00000000", instr, instr_valid, out_PC);
    end
    tick();
    use_INT_INSTR = 1'b0;
    push_seq(32'h0, 8);
    drain(200, 1'b0, "inject");
    use_cpu_injection = 1'b1; flush = 1'b1; in_PC_next = 32'h300;
    #1;
    n_checks++;
    if (instr_valid !== 1'b0 || instr !== NOP_EXP) begin
      n_fail++;
      $display("FAIL inject_redirect: valid=%b instr=%h, required 0 %h", instr_valid, instr, NOP_EXP);
    end
    tick();
    flush = 1'b0; use_cpu_injection = 1'b0; stall = 1'b0;
    push_seq(32'h300, 4);
    drain(100, 1'b0, "inject_flush");
  endtask

  task automatic test_reset_mid();
    bit first = 1'b1;
    do_reset();
    rsp_delay = 3; gnt_pct = 100;
    wait_req("rst_mid");
    tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0 || instr !== NOP_EXP || instr_valid !== 1'b0 ||
        out_PC !== 32'h0 || Done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_out: req=%b addr=%h instr=%h valid=%b pc=%h done=%b, required reset values",
               mem_req, mem_addr, instr, instr_valid, out_PC, Done);
    end
    tick();
    rst_n = 1'b1;
    push_seq(32'h0, 4);
    sb_on = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      #1;
      if (first && mem_rvalid) begin
        first = 1'b0;
        n_checks++;
        if (Done !== 1'b0) begin
          n_fail++;
          $display("FAIL rst_mid_late_rvalid: Done=%b, required 0", Done);
        end
      end
    end
    drain(200, 1'b0, "rst_mid");
    rsp_delay = 1;
  endtask

  task automatic test_wrap();
    int n = 0;
    do_reset();
    addr2_q.delete();
    while (addr2_q.size() < 3 && n < 40) begin
      tick();
      n++;
    end
    repeat (12) tick();
    n_checks++;
    if (addr2_q.size() < 3) begin
      n_fail++;
      $display("FAIL wrap_grants: %0d grants, required at least 3", addr2_q.size());
    end else begin
      n_checks += 2;
      if (addr2_q[0] !== 32'hFFFF_FFF8 || addr2_q[1] !== 32'hFFFF_FFFC) begin
        n_fail++;
        $display("FAIL wrap_addr01: %h %h, required fffffff8 fffffffc", addr2_q[0], addr2_q[1]);
      end
      if (addr2_q[2] !== 32'h0000_0000) begin
        n_fail++;
        $display("FAIL wrap_addr2: %h, required 00000000", addr2_q[2]);
      end
    end
    n_checks++;
    if (out_PC2 !== WRAP_PC || current_PC2 !== WRAP_PC || instr2 !== (WRAP_PC ^ XOR_KEY) || instr_valid2 !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_head: pc=%h cur=%h instr=%h valid=%b, required %h %h %h 1",
               out_PC2, current_PC2, instr2, instr_valid2, WRAP_PC, WRAP_PC, WRAP_PC ^ XOR_KEY);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    rsp_delay = 2; gnt_pct = 50;
    push_seq(32'h0, 20);
    drain(2000, 1'b1, "b2b");
    rsp_delay = 1; gnt_pct = 100;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; restore = 1'b0;
    use_cpu_injection = 1'b0; use_INT_INSTR = 1'b0;
    in_PC_next = '0; PC_before_int = '0; cpu_injection = '0; INT_INSTR = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_restore();
    test_redirect_req();
    test_inject();
    test_reset_mid();
    test_wrap();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_prefetch.md
Name: fetch_prefetch

Overview:
- Next-generation fetch stage.
- Decouples instruction memory latency from decode with a parametrised prefetch queue of (PC, instruction) pairs.
- Issues sequential word fetches over a req/gnt/rvalid handshake to the memory controller.
- Supports branch flush, interrupt restore and instruction injection from the CPU interrupt FSM or the interrupt controller.
- Sits between the memory controller host port and decode.

Parameters:
- XLEN, 32, instruction and address width.
- DEPTH, 4, prefetch queue entries (power of two, >=2).
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- stall  in  1  decode cannot accept; queue head held
- flush  in  1  redirect to in_PC_next
- in_PC_next  in  XLEN  branch/jump target
- restore  in  1  redirect to PC_before_int (priority over flush)
- PC_before_int  in  XLEN  return PC after interrupt
- use_cpu_injection  in  1  present cpu_injection instead of queue head
- cpu_injection  in  XLEN  injected instruction from CPU interrupt FSM
- use_INT_INSTR  in  1  present INT_INSTR instead of queue head
- INT_INSTR  in  XLEN  injected instruction from interrupt controller
- mem_req  out  1  fetch request
- mem_addr  out  XLEN  fetch address
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  response data valid
- mem_rdata  in  XLEN  response instruction
- instr  out  XLEN  instruction to decode
- instr_valid  out  1  instr is meaningful
- out_PC  out  XLEN  PC of instr
- current_PC  out  XLEN  head PC if queue non-empty, else fetch PC
- Done  out  1  response accepted into queue this cycle

Behaviour:
- Reset (async):
  - fetch_pc=RESET_PC; queue empty; FSM=IDLE.
  - mem_req=0, mem_addr=RESET_PC.
  - instr=NOP, instr_valid=0, out_PC=RESET_PC, Done=0.
- FSM states: IDLE, REQ, WAIT, DROP. At most one request outstanding.
  - IDLE->REQ when count<DEPTH (space reserved for the outstanding response).
  - REQ: mem_req=1, mem_addr=fetch_pc. mem_gnt -> WAIT.
  - WAIT: on mem_rvalid push {fetch_pc, mem_rdata}, fetch_pc+=PC_STEP (wraps mod 2^XLEN), Done=1. Next state is REQ if space remains after the push/pop, else IDLE.
  - DROP: on mem_rvalid discard data (Done=0), go IDLE.
  - mem_rvalid outside WAIT/DROP is ignored.
- Redirect = restore | flush. Target = restore ? PC_before_int : in_PC_next.
  - Queue cleared.
  - fetch_pc<=target next cycle.
  - WAIT->DROP.
  - REQ with mem_gnt same cycle -> DROP.
  - REQ without gnt: stay REQ; mem_addr changes to target next cycle. Memory samples addr only at req&gnt.
  - Redirect while stall=1 still redirects.
  - Redirect cycle: instr=NOP (32'b01111 followed by zeros), instr_valid=0, no pop.
- Output is combinational from the queue head.
  - instr_valid = !empty & !redirect.
  - Pop when instr_valid & !stall & !use_cpu_injection & !use_INT_INSTR.
  - Empty queue: instr=NOP, instr_valid=0.
  - Push and pop in the same cycle allowed at any fill level, including full.
- Injection priority: use_cpu_injection > use_INT_INSTR > queue head.
  - While injecting: instr_valid=1, out_PC=current_PC, no pop. Prefetch continues.
  - Injection during redirect: redirect wins.
- Reset mid-request: FSM returns to IDLE. A late rvalid after reset is ignored.

Optional Feature:
- FETCH_PERF_CNT_EN defined adds outputs perf_fetched (32b) and perf_starve (32b).
  - perf_fetched: count of pushes.
  - perf_starve: cycles with empty queue, no redirect, no injection.
  - Both saturate at all-ones and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package fetch_pkg:
  - NOP_INSTR constant.
  - fetch_state_t enum {IDLE, REQ, WAIT, DROP}.
  - fetch_entry_t struct {pc, instr}.
- Sub-module fetch_fifo #(DEPTH, entry type width):
  - Synchronous clear, push, pop, count, full, empty.
  - Simultaneous push+pop when full permitted.

Test Plan:
- Reset, mem responds 1 cycle after gnt with rdata=addr^32'hA5A5_0000, stall=0 -> instr_valid stream of PCs 0,4,8,... with matching data, no gaps after fill.
- stall=1 for 10 cycles, DEPTH=4 -> queue fills, mem_req stays 0 once count reaches 4, head (PC 0x0) held. Release -> PCs 0x0,0x4,0x8,0xC in order.
- flush with in_PC_next=0x100 while in WAIT -> old response discarded (Done=0), instr=NOP that cycle, next valid instr has out_PC=0x100.
- restore and flush same cycle, PC_before_int=0x40, in_PC_next=0x80 -> refetch starts at 0x40.
- use_cpu_injection=1 with cpu_injection=0x1234_5678 for 3 cycles -> instr=0x12345678, instr_valid=1, queue head PC unchanged afterwards. Both injections asserted -> cpu_injection shown.
- RESET_PC=32'hFFFF_FFF8 -> fetch addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 (wrap). Assert rst_n low during WAIT -> outputs at reset values, late rvalid ignored.
